// File: rtl/ex_stage_if.sv
// Data SRAM request port driven by the execute stage.
//   en    : access enable (load or store present in EX)
//   wen   : per-byte write enables, 0 for loads
//   addr  : byte address, src1 + src2
//   wdata : store data replicated across the byte lanes
// master: the EX stage drives the request; slave: the SRAM side observes it.
interface ex_stage_if;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;

   modport master (output en, wen, addr, wdata);
   modport slave  (input  en, wen, addr, wdata);
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline (between ID and MEM).
// Latches the ID->EX bus, evaluates the ALU, multiplies in one cycle,
// divides in 32 restoring steps, and issues the data SRAM request.
//   clk, rst_n       : clock, asynchronous active-low reset
//   flush            : pipeline flush, clears the input register and divider
//   stall[5:0]       : stall bus, bit 2 holds EX, bit 3 holds MEM (1 = stop)
//   id_to_ex_bus     : {mem_op,st_op,alu_op,md_op,mt_op,pc,sel_rf_res,
//                       rf_we,rf_waddr,src1,src2,st_data}
//   ex_to_mem_bus    : {hilo_bus,mem_op,pc,data_ram_en,data_ram_wen,
//                       sel_rf_res,rf_we,rf_waddr,ex_result}
//   ex_fwd_bus       : {rf_we,rf_waddr,ex_result} for ID forwarding
//   ex_is_load       : a load sits in EX (load-use detection)
//   data_sram        : data SRAM request port
//   stallreq_for_ex  : divider busy, stall IF/ID/EX
module ex_stage #(
   parameter int ID_TO_EX_WD  = 161,
   parameter int HILO_WD      = 66,
   parameter int EX_TO_MEM_WD = HILO_WD + 81
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [5:0]              stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [37:0]             ex_fwd_bus,
   output logic                    ex_is_load,
   ex_stage_if.master              data_sram,
   output logic                    stallreq_for_ex
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_e;

   logic [ID_TO_EX_WD-1:0] bus_r;

   logic [4:0]  mem_op;
   logic [2:0]  st_op;
   logic [11:0] alu_op;
   logic [3:0]  md_op;
   logic [1:0]  mt_op;
   logic [31:0] pc;
   logic        sel_rf_res;
   logic        rf_we_in;
   logic [4:0]  rf_waddr;
   logic [31:0] src1, src2, st_data;

   logic        unused_stall;
   assign unused_stall = ^{stall[5:4], stall[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     bus_r <= '0;
      else if (flush)                 bus_r <= '0;
      else if (stall[2] && !stall[3]) bus_r <= '0;   // bubble into MEM
      else if (!stall[2])             bus_r <= id_to_ex_bus;
   end

   assign {mem_op, st_op, alu_op, md_op, mt_op, pc, sel_rf_res, rf_we_in,
           rf_waddr, src1, src2, st_data} = bus_r;

   // ALU, alu_op is one-hot
   logic [31:0] alu_res;
   logic [4:0]  shamt;
   assign shamt = src1[4:0];

   always_comb begin
      alu_res = '0;
      if      (alu_op[11]) alu_res = src1 + src2;
      else if (alu_op[10]) alu_res = src1 - src2;
      else if (alu_op[9])  alu_res = {31'b0, $signed(src1) < $signed(src2)};
      else if (alu_op[8])  alu_res = {31'b0, src1 < src2};
      else if (alu_op[7])  alu_res = src1 & src2;
      else if (alu_op[6])  alu_res = ~(src1 | src2);
      else if (alu_op[5])  alu_res = src1 | src2;
      else if (alu_op[4])  alu_res = src1 ^ src2;
      else if (alu_op[3])  alu_res = src2 << shamt;
      else if (alu_op[2])  alu_res = src2 >> shamt;
      else if (alu_op[1])  alu_res = $signed(src2) >>> shamt;
      else if (alu_op[0])  alu_res = {src2[15:0], 16'h0000};
   end

   // Load/store address and byte lanes
   logic        mem_en;
   logic [31:0] mem_addr, ex_result, wdata;
   logic [3:0]  wen;

   assign mem_en    = (|mem_op) | (|st_op);
   assign mem_addr  = src1 + src2;
   assign ex_result = mem_en ? mem_addr : alu_res;

   always_comb begin
      wen   = '0;
      wdata = st_data;
      if (st_op[2]) begin
         wen   = 4'b0001 << mem_addr[1:0];
         wdata = {4{st_data[7:0]}};
      end else if (st_op[1]) begin
         wen   = mem_addr[1] ? 4'b1100 : 4'b0011;
         wdata = {2{st_data[15:0]}};
      end else if (st_op[0]) begin
         wen   = 4'b1111;
      end
   end

   assign data_sram.en    = mem_en;
   assign data_sram.wen   = wen;
   assign data_sram.addr  = mem_addr;
   assign data_sram.wdata = wdata;

   // Divider
   div_state_e  state, state_nx;
   logic [5:0]  cnt;
   logic [31:0] rem_r, quo_r, dvsr_r;
   logic        q_neg, r_neg, dz;
   logic        is_div;
   logic [31:0] dvnd_mag, dvsr_mag;
   logic [32:0] shifted, trial;

   assign is_div   = md_op[1] | md_op[0];
   assign dvnd_mag = (md_op[1] && src1[31]) ? -src1 : src1;
   assign dvsr_mag = (md_op[1] && src2[31]) ? -src2 : src2;
   assign shifted  = {rem_r, quo_r[31]};
   assign trial    = shifted - {1'b0, dvsr_r};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx        = state;
      stallreq_for_ex = 1'b0;
      case (state)
         S_IDLE: if (is_div) begin
            stallreq_for_ex = 1'b1;
            state_nx        = S_RUN;
         end
         S_RUN: begin
            stallreq_for_ex = 1'b1;
            if (cnt == 6'd31) state_nx = S_DONE;
         end
         S_DONE: if (!stall[2]) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (flush) begin
         state_nx        = S_IDLE;
         stallreq_for_ex = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         rem_r  <= '0;
         quo_r  <= '0;
         dvsr_r <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         dz     <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (is_div) begin
               rem_r  <= '0;
               quo_r  <= dvnd_mag;
               dvsr_r <= dvsr_mag;
               q_neg  <= md_op[1] & (src1[31] ^ src2[31]);
               r_neg  <= md_op[1] & src1[31];
               dz     <= (src2 == 32'd0);
               cnt    <= '0;
            end
            S_RUN: begin
               // trial[32] set means the divisor did not fit: restore
               rem_r <= trial[32] ? shifted[31:0] : trial[31:0];
               quo_r <= {quo_r[30:0], ~trial[32]};
               cnt   <= cnt + 6'd1;
            end
            default: ;
         endcase
      end
   end

   // HI/LO producers
   logic [63:0] prod_s, prod_u;
   logic [31:0] hi, lo;
   logic        hi_we, lo_we, rf_we;

   assign prod_s = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});
   assign prod_u = {32'b0, src1} * {32'b0, src2};

   always_comb begin
      hi_we = 1'b0;
      lo_we = 1'b0;
      hi    = '0;
      lo    = '0;
      if (md_op[3]) begin
         {hi, lo} = prod_s;
         hi_we = 1'b1;
         lo_we = 1'b1;
      end else if (md_op[2]) begin
         {hi, lo} = prod_u;
         hi_we = 1'b1;
         lo_we = 1'b1;
      end else if (state == S_DONE) begin
         hi_we = 1'b1;
         lo_we = 1'b1;
         lo    = dz ? '1 : (q_neg ? -quo_r : quo_r);
         hi    = dz ? src1 : (r_neg ? -rem_r : rem_r);
      end else if (mt_op[1]) begin
         hi    = src1;
         hi_we = 1'b1;
      end else if (mt_op[0]) begin
         lo    = src1;
         lo_we = 1'b1;
      end
   end

   // Divides never write a GPR
   assign rf_we = rf_we_in & ~is_div;

   assign ex_to_mem_bus = {hi_we, lo_we, hi, lo, mem_op, pc, mem_en, wen,
                           sel_rf_res, rf_we, rf_waddr, ex_result};
   assign ex_fwd_bus    = {rf_we, rf_waddr, ex_result};
   assign ex_is_load    = |mem_op;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized
// instructions compared against a behavioural reference model.
module tb_ex_stage;

   typedef struct packed {
      logic [4:0]  mem_op;
      logic [2:0]  st_op;
      logic [11:0] alu_op;
      logic [3:0]  md_op;
      logic [1:0]  mt_op;
      logic [31:0] pc;
      logic        sel;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] sd;
   } instr_t;

   typedef struct packed {
      logic [146:0] mem_bus;
      logic [37:0]  fwd;
      logic         is_load;
      logic         en;
      logic [3:0]   wen;
      logic [31:0]  addr;
      logic [31:0]  wdata;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic [5:0]   stall;
   logic [160:0] id_to_ex_bus;
   logic [146:0] ex_to_mem_bus;
   logic [37:0]  ex_fwd_bus;
   logic         ex_is_load;
   logic         stallreq_for_ex;

   ex_stage_if sram();

   ex_stage #(.ID_TO_EX_WD(161), .HILO_WD(66), .EX_TO_MEM_WD(147)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .stall           (stall),
      .id_to_ex_bus    (id_to_ex_bus),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_fwd_bus      (ex_fwd_bus),
      .ex_is_load      (ex_is_load),
      .data_sram       (sram),
      .stallreq_for_ex (stallreq_for_ex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     nvec = 0;
   int     nerr = 0;
   instr_t cur;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [146:0] got, input logic [146:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model: what EX must present for instruction i
   function automatic exp_t model(input instr_t i, input bit done);
      exp_t        e;
      logic [31:0] addr, res, hi, lo, wd;
      logic [3:0]  wen;
      logic        hwe, lwe, we, en;
      logic [63:0] p;
      longint      a, b;
      addr = i.s1 + i.s2;
      a = longint'($signed(i.s1));
      b = longint'($signed(i.s2));
      res = 32'd0;
      if      (i.alu_op[11]) res = i.s1 + i.s2;
      else if (i.alu_op[10]) res = i.s1 - i.s2;
      else if (i.alu_op[9])  res = (a < b) ? 32'd1 : 32'd0;
      else if (i.alu_op[8])  res = (i.s1 < i.s2) ? 32'd1 : 32'd0;
      else if (i.alu_op[7])  res = i.s1 & i.s2;
      else if (i.alu_op[6])  res = ~(i.s1 | i.s2);
      else if (i.alu_op[5])  res = i.s1 | i.s2;
      else if (i.alu_op[4])  res = i.s1 ^ i.s2;
      else if (i.alu_op[3])  res = i.s2 << i.s1[4:0];
      else if (i.alu_op[2])  res = i.s2 >> i.s1[4:0];
      else if (i.alu_op[1])  res = 32'(b >>> i.s1[4:0]);
      else if (i.alu_op[0])  res = {i.s2[15:0], 16'h0000};
      en = (|i.mem_op) || (|i.st_op);
      if (en) res = addr;
      wen = 4'd0;
      wd  = i.sd;
      if (i.st_op[2]) begin
         case (addr[1:0])
            2'd0: wen = 4'b0001;
            2'd1: wen = 4'b0010;
            2'd2: wen = 4'b0100;
            default: wen = 4'b1000;
         endcase
         wd = {4{i.sd[7:0]}};
      end else if (i.st_op[1]) begin
         wen = addr[1] ? 4'b1100 : 4'b0011;
         wd  = {2{i.sd[15:0]}};
      end else if (i.st_op[0]) begin
         wen = 4'b1111;
      end
      hwe = 0; lwe = 0; hi = 0; lo = 0;
      if (i.md_op[3]) begin
         p = 64'(a * b);
         {hi, lo} = p; hwe = 1; lwe = 1;
      end else if (i.md_op[2]) begin
         p = {32'd0, i.s1} * {32'd0, i.s2};
         {hi, lo} = p; hwe = 1; lwe = 1;
      end else if (done) begin
         hwe = 1; lwe = 1;
         if (i.s2 == 0) begin
            lo = 32'hFFFFFFFF; hi = i.s1;
         end else if (i.md_op[1]) begin
            lo = 32'(a / b); hi = 32'(a % b);
         end else begin
            lo = i.s1 / i.s2; hi = i.s1 % i.s2;
         end
      end else if (i.mt_op[1]) begin
         hi = i.s1; hwe = 1;
      end else if (i.mt_op[0]) begin
         lo = i.s1; lwe = 1;
      end
      we = i.we & ~(i.md_op[1] | i.md_op[0]);
      e.mem_bus = {hwe, lwe, hi, lo, i.mem_op, i.pc, en, wen, i.sel, we, i.waddr, res};
      e.fwd     = {we, i.waddr, res};
      e.is_load = |i.mem_op;
      e.en      = en;
      e.wen     = wen;
      e.addr    = addr;
      e.wdata   = wd;
      return e;
   endfunction

   task automatic check_all(input bit done, input logic exp_stall);
      exp_t e;
      e = model(cur, done);
      chk("ex_to_mem_bus", ex_to_mem_bus, e.mem_bus);
      chk("ex_fwd_bus", ex_fwd_bus, e.fwd);
      chk("ex_is_load", ex_is_load, e.is_load);
      chk("sram_en", sram.en, e.en);
      chk("sram_wen", sram.wen, e.wen);
      chk("sram_addr", sram.addr, e.addr);
      chk("sram_wdata", sram.wdata, e.wdata);
      chk("stallreq", stallreq_for_ex, exp_stall);
   endtask

   // Drive one cycle of inputs and track what the input register should hold
   task automatic step(input instr_t nx, input logic [5:0] st, input logic fl);
      @(negedge clk);
      id_to_ex_bus = nx;
      stall        = st;
      flush        = fl;
      if (fl)                    cur = '0;
      else if (st[2] && !st[3])  cur = '0;
      else if (!st[2])           cur = nx;
      @(posedge clk);
      #1;
   endtask

   function automatic instr_t rand_instr();
      instr_t i;
      i = '0;
      i.pc = $urandom; i.sel = 1'($urandom); i.we = 1'($urandom);
      i.waddr = 5'($urandom); i.s1 = $urandom; i.s2 = $urandom; i.sd = $urandom;
      case ($urandom_range(0, 5))
         0, 1: i.alu_op = 12'd1 << $urandom_range(0, 11);
         2:    i.mem_op = 5'd1 << $urandom_range(0, 4);
         3:    i.st_op  = 3'd1 << $urandom_range(0, 2);
         4:    i.md_op  = $urandom_range(0, 1) ? 4'b1000 : 4'b0100;
         default: i.mt_op = $urandom_range(0, 1) ? 2'b10 : 2'b01;
      endcase
      return i;
   endfunction

   function automatic instr_t div_instr(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      instr_t i;
      i = rand_instr();
      i.mem_op = '0; i.st_op = '0; i.alu_op = '0; i.mt_op = '0;
      i.md_op = sgn ? 4'b0010 : 4'b0001;
      i.s1 = a; i.s2 = b;
      return i;
   endfunction

   // Issue a divide, count stall-request cycles, check the DONE result
   task automatic run_div(input instr_t d);
      int hi_cnt;
      step(d, 6'b000000, 1'b0);
      hi_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (!stallreq_for_ex) break;
         hi_cnt++;
         check_all(1'b0, 1'b1);
         step(rand_instr(), 6'b001111, 1'b0);
      end
      chk("div_stall_cycles", 147'(hi_cnt), 147'd33);
      check_all(1'b1, 1'b0);
   endtask

   initial begin
      instr_t t;
      cur = '0;
      rst_n = 1'b0; flush = 1'b0; stall = '0;
      id_to_ex_bus = rand_instr();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check_all(1'b0, 1'b0);
         id_to_ex_bus = rand_instr();
      end
      @(negedge clk);
      rst_n = 1'b1;

      // first bus latched after release
      t = rand_instr();
      step(t, 6'b000000, 1'b0);
      check_all(1'b0, 1'b0);

      // sb
      t = '0; t.st_op = 3'b100; t.s1 = 32'h1000; t.s2 = 32'd3; t.sd = 32'hAB;
      step(t, 6'b000000, 1'b0);
      check_all(1'b0, 1'b0);
      chk("sb_addr", sram.addr, 147'h1003);
      chk("sb_wen", sram.wen, 147'b1000);
      chk("sb_wdata", sram.wdata, 147'hABABABAB);
      chk("sb_result", ex_to_mem_bus[31:0], 147'h1003);

      // sh
      t = '0; t.st_op = 3'b010; t.s1 = 32'h2000; t.s2 = 32'd2; t.sd = 32'h1234;
      step(t, 6'b000000, 1'b0);
      check_all(1'b0, 1'b0);
      chk("sh_wen", sram.wen, 147'b1100);
      chk("sh_wdata", sram.wdata, 147'h12341234);

      // lw
      t = '0; t.mem_op = 5'b00001; t.s1 = 32'h3000; t.s2 = 32'd8; t.we = 1'b1;
      step(t, 6'b000000, 1'b0);
      check_all(1'b0, 1'b0);
      chk("lw_wen", sram.wen, 147'd0);
      chk("lw_en", sram.en, 147'd1);
      chk("lw_is_load", ex_is_load, 147'd1);

      // div -7 / 2
      run_div(div_instr(1'b1, 32'hFFFFFFF9, 32'd2));
      chk("div_lo", ex_to_mem_bus[112:81], 147'hFFFFFFFD);
      chk("div_hi", ex_to_mem_bus[144:113], 147'hFFFFFFFF);
      chk("div_we", ex_to_mem_bus[146:145], 147'b11);
      step('0, 6'b000000, 1'b0);

      // divu by zero
      run_div(div_instr(1'b0, 32'd5, 32'd0));
      chk("divz_lo", ex_to_mem_bus[112:81], 147'hFFFFFFFF);
      chk("divz_hi", ex_to_mem_bus[144:113], 147'd5);
      step('0, 6'b000000, 1'b0);

      // flush in the middle of a divide (RUN, cnt = 10)
      step(div_instr(1'b1, $urandom, $urandom), 6'b000000, 1'b0);
      for (int k = 0; k < 11; k++) step(rand_instr(), 6'b001111, 1'b0);
      check_all(1'b0, 1'b1);
      step(rand_instr(), 6'b001111, 1'b1);
      check_all(1'b0, 1'b0);
      t = rand_instr(); t.md_op = '0;
      step(t, 6'b000000, 1'b0);
      check_all(1'b0, 1'b0);

      // bubble and hold
      t = rand_instr();
      step(t, 6'b000000, 1'b0);
      step(rand_instr(), 6'b000100, 1'b0);
      check_all(1'b0, 1'b0);
      chk("bubble_bus", ex_to_mem_bus, 147'd0);
      step(t, 6'b000000, 1'b0);
      step(rand_instr(), 6'b001100, 1'b0);
      check_all(1'b0, 1'b0);

      // sra / sltu / slt
      t = '0; t.alu_op = 12'b000000000010; t.s1 = 32'd4; t.s2 = 32'h80000000;
      step(t, 6'b000000, 1'b0);
      check_all(1'b0, 1'b0);
      chk("sra", ex_to_mem_bus[31:0], 147'hF8000000);
      t = '0; t.alu_op = 12'b000100000000; t.s1 = 32'd1; t.s2 = 32'hFFFFFFFF;
      step(t, 6'b000000, 1'b0);
      chk("sltu", ex_to_mem_bus[31:0], 147'd1);
      t.alu_op = 12'b001000000000;
      step(t, 6'b000000, 1'b0);
      chk("slt", ex_to_mem_bus[31:0], 147'd0);

      // randomized instruction stream with stalls and flushes
      for (int k = 0; k < 120; k++) begin
         logic [5:0] st;
         logic       fl;
         case ($urandom_range(0, 7))
            0:       st = 6'b000100;
            1:       st = 6'b001100;
            default: st = 6'b000000;
         endcase
         fl = ($urandom_range(0, 15) == 0);
         step(rand_instr(), st, fl);
         check_all(1'b0, 1'b0);
      end

      // randomized divides
      for (int k = 0; k < 6; k++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = (k == 5) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
         run_div(div_instr(k[0], a, b));
         step('0, 6'b000000, 1'b0);
         check_all(1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
